// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 status display: command/ASCII constants,
// sequencing states, byte-writer phases and the nibble-to-ASCII helper.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_1     = 8'h31;
  localparam logic [7:0] ASC_B     = 8'h42;
  localparam logic [7:0] ASC_I     = 8'h49;
  localparam logic [7:0] ASC_N     = 8'h4E;
  localparam logic [7:0] ASC_H     = 8'h48;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_X     = 8'h58;
  localparam logic [7:0] ASC_COLON = 8'h3A;

  localparam int LINE_CHARS = 16;
  localparam int INIT_BYTES = 5;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT, IDLE, SNAP, ADDR1, LINE1, ADDR2, LINE2, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD
  } phase_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] init_byte(input logic [4:0] i);
    case (i)
      5'd0, 5'd1: return CMD_FUNC_SET;
      5'd2:       return CMD_DISP_ON;
      5'd3:       return CMD_CLEAR;
      default:    return CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 write transaction: setup cycle, E_CYCLES of lcd_e high, then a
// hold of CMD_CYCLES or CLR_CYCLES. ready rises in the last hold cycle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int CMD_CYCLES = 2_500,
  parameter int CLR_CYCLES = 100_000,
  parameter int E_CYCLES   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] byte_data,
  input  logic       long_wait,
  output logic       ready,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int MAX_WAIT = (CLR_CYCLES > CMD_CYCLES) ? CLR_CYCLES : CMD_CYCLES;
  localparam int MAX_CYC  = (MAX_WAIT > E_CYCLES) ? MAX_WAIT : E_CYCLES;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);

  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             long_q, long_n;
  logic             e_n, rs_n;
  logic [7:0]       data_n;

  // Back-to-back bytes: the next setup cycle follows the final hold cycle.
  assign ready = (phase == PH_IDLE) || ((phase == PH_HOLD) && (cnt == '0));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    long_n  = long_q;
    e_n     = lcd_e;
    rs_n    = lcd_rs;
    data_n  = lcd_data;
    if (start && ready) begin
      phase_n = PH_SETUP;
      rs_n    = rs;
      data_n  = byte_data;
      long_n  = long_wait;
      e_n     = 1'b0;
    end else begin
      case (phase)
        PH_SETUP: begin
          e_n     = 1'b1;
          cnt_n   = CNT_W'(E_CYCLES - 1);
          phase_n = PH_PULSE;
        end
        PH_PULSE: begin
          if (cnt == '0) begin
            e_n     = 1'b0;
            cnt_n   = long_q ? CNT_W'(CLR_CYCLES - 1) : CNT_W'(CMD_CYCLES - 1);
            phase_n = PH_HOLD;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        PH_HOLD: begin
          if (cnt == '0) phase_n = PH_IDLE;
          else           cnt_n   = cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      long_q   <= long_n;
      lcd_e    <= e_n;
      lcd_rs   <= rs_n;
      lcd_data <= data_n;
    end
  end

endmodule

// File: rtl/lcd_status_display.sv
// HD44780 16x2 status display: power-on init, then redraws "BIN:" and "HEX:"
// lines from input snapshots whenever the inputs change or a refresh is requested.
module lcd_status_display
  import lcd_pkg::*;
#(
  parameter int BIN_WIDTH     = 4,
  parameter int NUM_HEX_BYTES = 1,
  parameter int PWR_CYCLES    = 1_000_000,
  parameter int CMD_CYCLES    = 2_500,
  parameter int CLR_CYCLES    = 100_000,
  parameter int E_CYCLES      = 25
) (
  input  logic                       clock_50,
  input  logic                       reset,
  input  logic [BIN_WIDTH-1:0]       binary_input,
  input  logic [8*NUM_HEX_BYTES-1:0] hex_input,
  input  logic                       refresh_req,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       lcd_rs,
  output logic                       lcd_e,
  output logic                       lcd_rw,
  output logic                       lcd_on,
  output logic                       lcd_blon,
  inout  wire  [7:0]                 lcd_data
);

  localparam int HEX_W = 8 * NUM_HEX_BYTES;
  localparam int PWR_W = $clog2(PWR_CYCLES + 1);

  if (BIN_WIDTH < 1 || BIN_WIDTH > 12) begin : g_bad_bin_width
    $error("lcd_status_display: BIN_WIDTH must be in 1..12");
  end
  if (NUM_HEX_BYTES < 1 || NUM_HEX_BYTES > 6) begin : g_bad_hex_bytes
    $error("lcd_status_display: NUM_HEX_BYTES must be in 1..6");
  end

  state_t               state, state_n;
  logic [4:0]           idx, idx_n;
  logic [PWR_W-1:0]     pwr_cnt, pwr_n;
  logic [BIN_WIDTH-1:0] bin_snap, bin_n;
  logic [HEX_W-1:0]     hex_snap, hex_n;

  logic       wr_start, wr_rs, wr_ready, wr_long;
  logic [7:0] wr_byte, data_out;

  function automatic logic [7:0] line1_char(input logic [4:0] i, input logic [BIN_WIDTH-1:0] v);
    int p = int'(i);
    logic [BIN_WIDTH-1:0] sh;
    case (p)
      0: return ASC_B;
      1: return ASC_I;
      2: return ASC_N;
      3: return ASC_COLON;
      default: begin
        if (p >= 4 + BIN_WIDTH) return ASC_SPACE;
        sh = v >> (BIN_WIDTH + 3 - p);
        return sh[0] ? ASC_1 : ASC_0;
      end
    endcase
  endfunction

  function automatic logic [7:0] line2_char(input logic [4:0] i, input logic [HEX_W-1:0] v);
    int p = int'(i);
    logic [HEX_W-1:0] sh;
    case (p)
      0: return ASC_H;
      1: return ASC_E;
      2: return ASC_X;
      3: return ASC_COLON;
      default: begin
        if (p >= 4 + 2 * NUM_HEX_BYTES) return ASC_SPACE;
        sh = v >> (4 * (2 * NUM_HEX_BYTES + 3 - p));
        return nibble_to_ascii(sh[3:0]);
      end
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    pwr_n    = pwr_cnt;
    bin_n    = bin_snap;
    hex_n    = hex_snap;
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_byte  = 8'h00;
    case (state)
      PWR_WAIT: begin
        if (pwr_cnt == PWR_W'(PWR_CYCLES - 1)) begin
          state_n = INIT;
          pwr_n   = '0;
        end else begin
          pwr_n = pwr_cnt + 1'b1;
        end
      end
      INIT: if (wr_ready) begin
        if (idx == 5'(INIT_BYTES)) begin
          state_n = SNAP;
          idx_n   = '0;
        end else begin
          wr_start = 1'b1;
          wr_byte  = init_byte(idx);
          idx_n    = idx + 1'b1;
        end
      end
      IDLE: begin
        if (refresh_req || (binary_input != bin_snap) || (hex_input != hex_snap))
          state_n = SNAP;
      end
      SNAP: begin
        bin_n   = binary_input;
        hex_n   = hex_input;
        state_n = ADDR1;
      end
      ADDR1, ADDR2: if (wr_ready) begin
        if (idx == 5'd1) begin
          state_n = (state == ADDR1) ? LINE1 : LINE2;
          idx_n   = '0;
        end else begin
          wr_start = 1'b1;
          wr_byte  = (state == ADDR1) ? CMD_LINE1 : CMD_LINE2;
          idx_n    = 5'd1;
        end
      end
      LINE1, LINE2: if (wr_ready) begin
        if (idx == 5'(LINE_CHARS)) begin
          state_n = (state == LINE1) ? ADDR2 : DONE;
          idx_n   = '0;
        end else begin
          wr_start = 1'b1;
          wr_rs    = 1'b1;
          wr_byte  = (state == LINE1) ? line1_char(idx, bin_snap) : line2_char(idx, hex_snap);
          idx_n    = idx + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state    <= PWR_WAIT;
      idx      <= '0;
      pwr_cnt  <= '0;
      bin_snap <= '0;
      hex_snap <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      pwr_cnt  <= pwr_n;
      bin_snap <= bin_n;
      hex_snap <= hex_n;
    end
  end

  // Only the clear command needs the long settle time; characters are never 0x01.
  assign wr_long = !wr_rs && (wr_byte == CMD_CLEAR);

  lcd_byte_writer #(
    .CMD_CYCLES(CMD_CYCLES),
    .CLR_CYCLES(CLR_CYCLES),
    .E_CYCLES  (E_CYCLES)
  ) u_writer (
    .clk      (clock_50),
    .rst      (reset),
    .start    (wr_start),
    .rs       (wr_rs),
    .byte_data(wr_byte),
    .long_wait(wr_long),
    .ready    (wr_ready),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (data_out)
  );

  assign lcd_data   = data_out;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign lcd_rw     = 1'b0;
  assign lcd_on     = 1'b1;
  assign lcd_blon   = 1'b1;

endmodule
